// File: rtl/bh_pkg.sv
// Shared brainhack definitions: opcode encoding, loader states and loader error codes.
package bh_pkg;

    localparam int INSTR_W = 3;

    localparam logic [INSTR_W-1:0] OP_NOP   = 3'b000;
    localparam logic [INSTR_W-1:0] OP_INC   = 3'b010;
    localparam logic [INSTR_W-1:0] OP_DEC   = 3'b011;
    localparam logic [INSTR_W-1:0] OP_RIGHT = 3'b100;
    localparam logic [INSTR_W-1:0] OP_LEFT  = 3'b101;
    localparam logic [INSTR_W-1:0] OP_OPEN  = 3'b110;
    localparam logic [INSTR_W-1:0] OP_CLOSE = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_CLEAR,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_UNDERFLOW  = 3'd1;
    localparam logic [2:0] ERR_DEPTH      = 3'd2;
    localparam logic [2:0] ERR_UNBALANCED = 3'd3;
    localparam logic [2:0] ERR_LENGTH     = 3'd4;

endpackage

// File: rtl/bf_decode.sv
// ASCII Brainfuck character classifier: flags instructions and the NUL terminator,
// and maps instruction characters to opcodes.
module bf_decode
    import bh_pkg::*;
(
    input  logic [7:0]         src_byte,
    output logic               is_instr,
    output logic               is_term,
    output logic [INSTR_W-1:0] opcode
);

    always_comb begin
        is_instr = 1'b1;
        is_term  = 1'b0;
        opcode   = OP_NOP;
        case (src_byte)
            8'h2B: opcode = OP_INC;
            8'h2D: opcode = OP_DEC;
            8'h3E: opcode = OP_RIGHT;
            8'h3C: opcode = OP_LEFT;
            8'h5B: opcode = OP_OPEN;
            8'h5D: opcode = OP_CLOSE;
            8'h00: begin
                is_instr = 1'b0;
                is_term  = 1'b1;
            end
            default: is_instr = 1'b0;
        endcase
    end

endmodule

// File: rtl/bf_loader.sv
// Program loader: streams ASCII source into program memory as opcodes, checks
// bracket balance, pads with NOP, zeroes the tape, then releases the core.
module bf_loader
    import bh_pkg::*;
#(
    parameter int PRG_AW    = 8,
    parameter int TAPE_AW   = 8,
    parameter int TAPE_DW   = 8,
    parameter int MAX_DEPTH = 16
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    output logic               o_byte_ready,
    output logic               o_prgmem_we,
    output logic [PRG_AW-1:0]  o_prgmem_addr,
    output logic [INSTR_W-1:0] o_prgmem_data,
    output logic               o_tape_we,
    output logic [TAPE_AW-1:0] o_tape_addr,
    output logic [TAPE_DW-1:0] o_tape_data,
    output logic [PRG_AW:0]    o_prog_len,
    output logic               o_busy,
    output logic               o_cpu_run,
    output logic               o_error,
    output logic [2:0]         o_error_code
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam logic [PRG_AW:0]      PRG_DEPTH = {1'b1, {PRG_AW{1'b0}}};
    localparam logic [PRG_AW-1:0]    PRG_LAST  = {PRG_AW{1'b1}};
    localparam logic [TAPE_AW-1:0]   TAPE_LAST = {TAPE_AW{1'b1}};
    localparam logic [DEPTH_W-1:0]   DEPTH_MAX = DEPTH_W'(MAX_DEPTH);

    loader_state_t      state_reg, state_next;
    logic [PRG_AW:0]    count_reg, count_next;
    logic [DEPTH_W-1:0] depth_reg, depth_next;
    logic [2:0]         err_code_reg, err_code_next;
    logic [PRG_AW:0]    prog_len_reg, prog_len_next;
    logic               prg_we_reg, prg_we_next;
    logic [PRG_AW-1:0]  prg_addr_reg, prg_addr_next;
    logic [INSTR_W-1:0] prg_data_reg, prg_data_next;
    logic               tape_we_reg, tape_we_next;
    logic [TAPE_AW-1:0] tape_addr_reg, tape_addr_next;

    logic               dec_is_instr;
    logic               dec_is_term;
    logic [INSTR_W-1:0] dec_opcode;

    bf_decode u_decode (
        .src_byte (i_byte),
        .is_instr (dec_is_instr),
        .is_term  (dec_is_term),
        .opcode   (dec_opcode)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Write strobes are issued so that they line up with the state that owns them:
    // the first PAD/CLEAR write is loaded on the transition into that state.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        depth_next     = depth_reg;
        err_code_next  = err_code_reg;
        prog_len_next  = prog_len_reg;
        prg_we_next    = 1'b0;
        prg_addr_next  = prg_addr_reg;
        prg_data_next  = prg_data_reg;
        tape_we_next   = 1'b0;
        tape_addr_next = tape_addr_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_next    = ST_LOAD;
                    count_next    = '0;
                    depth_next    = '0;
                    err_code_next = ERR_NONE;
                    prog_len_next = '0;
                end
            end
            ST_LOAD: begin
                if (i_byte_valid && dec_is_term) begin
                    if (depth_reg != '0) begin
                        err_code_next = ERR_UNBALANCED;
                        state_next    = ST_ERROR;
                    end else begin
                        prog_len_next = count_reg;
                        if (count_reg == PRG_DEPTH) begin
                            state_next     = ST_CLEAR;
                            tape_we_next   = 1'b1;
                            tape_addr_next = '0;
                        end else begin
                            state_next    = ST_PAD;
                            prg_we_next   = 1'b1;
                            prg_addr_next = count_reg[PRG_AW-1:0];
                            prg_data_next = OP_NOP;
                        end
                    end
                end else if (i_byte_valid && dec_is_instr) begin
                    if (count_reg == PRG_DEPTH) begin
                        err_code_next = ERR_LENGTH;
                        state_next    = ST_ERROR;
                    end else if (dec_opcode == OP_CLOSE && depth_reg == '0) begin
                        err_code_next = ERR_UNDERFLOW;
                        state_next    = ST_ERROR;
                    end else if (dec_opcode == OP_OPEN && depth_reg == DEPTH_MAX) begin
                        err_code_next = ERR_DEPTH;
                        state_next    = ST_ERROR;
                    end else begin
                        prg_we_next   = 1'b1;
                        prg_addr_next = count_reg[PRG_AW-1:0];
                        prg_data_next = dec_opcode;
                        count_next    = count_reg + 1'b1;
                        if (dec_opcode == OP_OPEN) begin
                            depth_next = depth_reg + 1'b1;
                        end else if (dec_opcode == OP_CLOSE) begin
                            depth_next = depth_reg - 1'b1;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (prg_addr_reg == PRG_LAST) begin
                    state_next     = ST_CLEAR;
                    tape_we_next   = 1'b1;
                    tape_addr_next = '0;
                end else begin
                    prg_we_next   = 1'b1;
                    prg_addr_next = prg_addr_reg + 1'b1;
                    prg_data_next = OP_NOP;
                end
            end
            ST_CLEAR: begin
                if (tape_addr_reg == TAPE_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    tape_we_next   = 1'b1;
                    tape_addr_next = tape_addr_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_byte_ready = 1'b0;
        o_busy       = 1'b0;
        o_cpu_run    = 1'b0;
        o_error      = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
            end
            ST_PAD, ST_CLEAR: o_busy    = 1'b1;
            ST_DONE:          o_cpu_run = 1'b1;
            ST_ERROR:         o_error   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            count_reg     <= '0;
            depth_reg     <= '0;
            err_code_reg  <= ERR_NONE;
            prog_len_reg  <= '0;
            prg_we_reg    <= 1'b0;
            prg_addr_reg  <= '0;
            prg_data_reg  <= '0;
            tape_we_reg   <= 1'b0;
            tape_addr_reg <= '0;
        end else begin
            count_reg     <= count_next;
            depth_reg     <= depth_next;
            err_code_reg  <= err_code_next;
            prog_len_reg  <= prog_len_next;
            prg_we_reg    <= prg_we_next;
            prg_addr_reg  <= prg_addr_next;
            prg_data_reg  <= prg_data_next;
            tape_we_reg   <= tape_we_next;
            tape_addr_reg <= tape_addr_next;
        end
    end

    assign o_prgmem_we   = prg_we_reg;
    assign o_prgmem_addr = prg_addr_reg;
    assign o_prgmem_data = prg_data_reg;
    assign o_tape_we     = tape_we_reg;
    assign o_tape_addr   = tape_addr_reg;
    assign o_tape_data   = '0;
    assign o_prog_len    = prog_len_reg;
    assign o_error_code  = err_code_reg;

endmodule

// File: tb/tb_bf_loader.sv
// Directed bench for bf_loader: every program-memory write is matched against a
// scoreboard filled by a small reference model as bytes are streamed in.
module tb_bf_loader;

    logic       i_clock = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       i_byte_valid = 1'b0;
    logic       o_byte_ready;
    logic       o_prgmem_we;
    logic [7:0] o_prgmem_addr;
    logic [2:0] o_prgmem_data;
    logic       o_tape_we;
    logic [7:0] o_tape_addr;
    logic [7:0] o_tape_data;
    logic [8:0] o_prog_len;
    logic       o_busy;
    logic       o_cpu_run;
    logic       o_error;
    logic [2:0] o_error_code;

    bf_loader dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_start       (i_start),
        .i_byte        (i_byte),
        .i_byte_valid  (i_byte_valid),
        .o_byte_ready  (o_byte_ready),
        .o_prgmem_we   (o_prgmem_we),
        .o_prgmem_addr (o_prgmem_addr),
        .o_prgmem_data (o_prgmem_data),
        .o_tape_we     (o_tape_we),
        .o_tape_addr   (o_tape_addr),
        .o_tape_data   (o_tape_data),
        .o_prog_len    (o_prog_len),
        .o_busy        (o_busy),
        .o_cpu_run     (o_cpu_run),
        .o_error       (o_error),
        .o_error_code  (o_error_code)
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic [7:0] addr;
        logic [2:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_assert = 0;
    int  n_fail = 0;
    int  tape_cnt = 0;
    int  prg_cnt = 0;
    int  m_cnt = 0;
    int  m_depth = 0;
    int  m_len = 0;
    int  m_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample registered outputs just after the edge and drain the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge i_clock);
        #1;
        if (o_prgmem_we) begin
            prg_cnt++;
            check("prg_write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("prg_addr", 64'(o_prgmem_addr), 64'(e.addr));
                check("prg_data", 64'(o_prgmem_data), 64'(e.data));
            end
        end
        if (o_tape_we) begin
            check("tape_addr", 64'(o_tape_addr), 64'(tape_cnt % 256));
            check("tape_data", 64'(o_tape_data), 64'd0);
            tape_cnt++;
        end
    endtask

    // Reference model of the loader's write/error behaviour for one accepted byte.
    task automatic model(input logic [7:0] b);
        logic [2:0] op;
        logic       instr;
        instr = 1'b1;
        op    = 3'b000;
        case (b)
            "+":     op = 3'b010;
            "-":     op = 3'b011;
            ">":     op = 3'b100;
            "<":     op = 3'b101;
            "[":     op = 3'b110;
            "]":     op = 3'b111;
            default: instr = 1'b0;
        endcase
        if (b == 8'h00) begin
            if (m_depth != 0) begin
                m_err = 3;
            end else begin
                m_len = m_cnt;
                for (int a = m_cnt; a < 256; a++) exp_q.push_back('{addr: a[7:0], data: 3'b000});
            end
        end else if (instr) begin
            if (m_cnt == 256) m_err = 4;
            else if (op == 3'b111 && m_depth == 0) m_err = 1;
            else if (op == 3'b110 && m_depth == 16) m_err = 2;
            else begin
                exp_q.push_back('{addr: m_cnt[7:0], data: op});
                m_cnt++;
                if (op == 3'b110) m_depth++;
                if (op == 3'b111) m_depth--;
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        check("byte_ready", 64'(o_byte_ready), 64'd1);
        i_byte       = b;
        i_byte_valid = 1'b1;
        model(b);
        tick();
        i_byte_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic start_load();
        exp_q.delete();
        m_cnt = 0; m_depth = 0; m_len = 0; m_err = 0;
        tape_cnt = 0; prg_cnt = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("start_busy", 64'(o_busy), 64'd1);
        check("start_cpu_run", 64'(o_cpu_run), 64'd0);
        check("start_error_code", 64'(o_error_code), 64'd0);
    endtask

    task automatic finish_load(input int exp_prg_writes);
        for (int i = 0; i < 2000 && !(o_cpu_run || o_error); i++) tick();
        check("end_timeout", 64'(o_cpu_run | o_error), 64'd1);
        tick();
        check("error_code", 64'(o_error_code), 64'(m_err));
        check("error_flag", 64'(o_error), 64'(m_err != 0));
        check("cpu_run", 64'(o_cpu_run), 64'(m_err == 0));
        check("busy_end", 64'(o_busy), 64'd0);
        check("byte_ready_end", 64'(o_byte_ready), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("prg_write_count", 64'(prg_cnt), 64'(exp_prg_writes));
        check("tape_write_count", 64'(tape_cnt), 64'(m_err == 0 ? 256 : 0));
        if (m_err == 0) check("prog_len", 64'(o_prog_len), 64'(m_len));
        $display("load done: prog_len=%0d err=%0d prg_writes=%0d tape_writes=%0d",
                 o_prog_len, o_error_code, prg_cnt, tape_cnt);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {o_byte_ready, o_prgmem_we, o_prgmem_addr, o_prgmem_data, o_tape_we,
                    o_tape_addr, o_tape_data, o_prog_len, o_busy, o_cpu_run, o_error,
                    o_error_code}, 64'd0);
    endtask

    initial begin
        i_reset_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset_outputs");
        i_reset_n = 1'b1;
        tick();
        check_all_zero("idle_outputs");

        // Basic loop program, padded to 256 and tape cleared.
        start_load();
        send_str("+[->+<]");
        send(8'h00);
        finish_load(256);

        // Comment characters are dropped; restart straight from DONE.
        start_load();
        send_str("a+ b\n-");
        send(8'h00);
        finish_load(256);

        // Unmatched close bracket.
        start_load();
        send_str("]");
        finish_load(0);

        // Nesting one deeper than the stack allows.
        start_load();
        for (int i = 0; i < 17; i++) send("[");
        finish_load(16);

        // Open bracket left unclosed at the terminator.
        start_load();
        send_str("[[]");
        send(8'h00);
        finish_load(3);

        // Exactly full program memory: no PAD phase.
        start_load();
        for (int i = 0; i < 256; i++) send("+");
        send(8'h00);
        finish_load(256);

        // One opcode too many.
        start_load();
        for (int i = 0; i < 257; i++) send("+");
        finish_load(256);

        // Reset in the middle of the tape clear.
        start_load();
        send("+");
        send(8'h00);
        for (int i = 0; i < 600 && !o_tape_we; i++) tick();
        check("clear_reached", 64'(o_tape_we), 64'd1);
        repeat (10) tick();
        i_reset_n = 1'b0;
        tick();
        check_all_zero("midclear_reset");
        i_reset_n = 1'b1;
        exp_q.delete();

        // Reload with valid toggling every other cycle.
        start_load();
        i_byte = "+";
        send("+");
        i_byte = "+";
        tick();
        send(8'h00);
        finish_load(256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
